mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_if.sv | 28 ++
 rtl/mem_wb_stage.sv | 176 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage_if
// Description : Data-memory request/response bus between the MEM/WB stage
//               (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_stage_if #(
  parameter int WORD_BITWIDTH = 32
);
  logic                     dmem_req;
  logic                     dmem_we;
  logic [WORD_BITWIDTH-1:0] dmem_addr;
  logic [WORD_BITWIDTH-1:0] dmem_wdata;
  logic                     dmem_ack;
  logic [WORD_BITWIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM stage with MEM/WB pipeline register. Issues loads/stores
//               on the data-memory bus, stalls upstream until the memory
//               acknowledges, and retires each instruction exactly once.
//               Optional feature macro MEM_WB_TIMEOUT_EN: aborts an access
//               that waits TIMEOUT_CYCLES without ack and sets sticky mem_err.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int WORD_BITWIDTH    = 32,
  parameter int TIMEOUT_CYCLES   = 15
) (
  input  wire logic                        clk,
  input  wire logic                        rst,   // active-low, asynchronous
  mem_wb_stage_if.master                   dmem,
  input  wire logic [WORD_BITWIDTH-1:0]    mem_ALUresult,
  input  wire logic [WORD_BITWIDTH-1:0]    mem_finalReadData2,
  input  wire logic                        mem_memRead,
  input  wire logic                        mem_memWrite,
  input  wire logic                        mem_wt_memToReg,
  input  wire logic                        mem_wt_regWrite,
  input  wire logic [REG_NUM_BITWIDTH-1:0] mem_wt_regToWrite,
  output logic                             mem_stall,
  output logic                             wb_memToReg,
  output logic                             wb_regWrite,
  output logic [REG_NUM_BITWIDTH-1:0]      wb_regToWrite,
  output logic [WORD_BITWIDTH-1:0]         wb_ALUresult,
  output logic [WORD_BITWIDTH-1:0]         wb_readData,
  output logic [WORD_BITWIDTH-1:0]         wb_writeData,
  output logic                             mem_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic access;
  logic load;    // take the instruction into WB this edge
  logic bubble;  // insert a non-retiring bubble into WB this edge

  logic                        wb_memToReg_q,   wb_memToReg_d;
  logic                        wb_regWrite_q,   wb_regWrite_d;
  logic [REG_NUM_BITWIDTH-1:0] wb_regToWrite_q, wb_regToWrite_d;
  logic [WORD_BITWIDTH-1:0]    wb_ALUresult_q,  wb_ALUresult_d;
  logic [WORD_BITWIDTH-1:0]    wb_readData_q,   wb_readData_d;

`ifdef MEM_WB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic [CNT_W-1:0] timeout_unused;
  assign timeout_unused = CNT_W'(TIMEOUT_CYCLES);
`endif

  assign access = mem_memRead | mem_memWrite;

  // Memory bus is driven straight from the EX/MEM inputs; a held request in
  // WAIT relies on upstream freezing those inputs. Reset drops req at once.
  assign dmem.dmem_req   = rst & ((state_q == S_WAIT) | access);
  assign dmem.dmem_we    = mem_memWrite;  // read+write together is a store
  assign dmem.dmem_addr  = mem_ALUresult;
  assign dmem.dmem_wdata = mem_finalReadData2;
  assign mem_stall       = dmem.dmem_req & ~dmem.dmem_ack;

  // Next-state logic: decide between retiring the instruction and a bubble.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    bubble  = 1'b0;
`ifdef MEM_WB_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!access || dmem.dmem_ack) begin
          load = 1'b1;
        end else begin
          bubble  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // An ack always wins over a timeout landing on the same cycle.
        if (dmem.dmem_ack) begin
          load    = 1'b1;
          state_d = S_IDLE;
        end else begin
          bubble = 1'b1;
`ifdef MEM_WB_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == TIMEOUT_VAL) begin
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // WB register next values: load the instruction, bubble, or hold.
  always_comb begin
    wb_memToReg_d   = wb_memToReg_q;
    wb_regWrite_d   = wb_regWrite_q;
    wb_regToWrite_d = wb_regToWrite_q;
    wb_ALUresult_d  = wb_ALUresult_q;
    wb_readData_d   = wb_readData_q;
    if (load) begin
      wb_memToReg_d   = mem_wt_memToReg;
      wb_regWrite_d   = mem_wt_regWrite;
      wb_regToWrite_d = mem_wt_regToWrite;
      wb_ALUresult_d  = mem_ALUresult;
      // Only a pure load returns memory data; stores and ALU ops carry 0.
      wb_readData_d   = (access && !mem_memWrite) ? dmem.dmem_rdata : '0;
    end else if (bubble) begin
      wb_memToReg_d = 1'b0;
      wb_regWrite_d = 1'b0;
    end
  end

  // State and WB pipeline registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      wb_memToReg_q   <= 1'b0;
      wb_regWrite_q   <= 1'b0;
      wb_regToWrite_q <= '0;
      wb_ALUresult_q  <= '0;
      wb_readData_q   <= '0;
    end else begin
      state_q         <= state_d;
      wb_memToReg_q   <= wb_memToReg_d;
      wb_regWrite_q   <= wb_regWrite_d;
      wb_regToWrite_q <= wb_regToWrite_d;
      wb_ALUresult_q  <= wb_ALUresult_d;
      wb_readData_q   <= wb_readData_d;
    end
  end

`ifdef MEM_WB_TIMEOUT_EN
  // Wait counter and sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

  assign wb_memToReg   = wb_memToReg_q;
  assign wb_regWrite   = wb_regWrite_q;
  assign wb_regToWrite = wb_regToWrite_q;
  assign wb_ALUresult  = wb_ALUresult_q;
  assign wb_readData   = wb_readData_q;
  assign wb_writeData  = wb_memToReg_q ? wb_readData_q : wb_ALUresult_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Randomized self-checking bench for mem_wb_stage with a
//               transaction-level reference model and a latency-driven
//               memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_ALUresult, mem_finalReadData2;
  logic        mem_memRead, mem_memWrite, mem_wt_memToReg, mem_wt_regWrite;
  logic [4:0]  mem_wt_regToWrite;
  logic        mem_stall, wb_memToReg, wb_regWrite, mem_err;
  logic [4:0]  wb_regToWrite;
  logic [31:0] wb_ALUresult, wb_readData, wb_writeData;

  mem_wb_stage_if #(.WORD_BITWIDTH(32)) dmem_bus ();

  mem_wb_stage #(
    .REG_NUM_BITWIDTH(5), .WORD_BITWIDTH(32), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .dmem(dmem_bus.master),
    .mem_ALUresult(mem_ALUresult), .mem_finalReadData2(mem_finalReadData2),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .mem_wt_memToReg(mem_wt_memToReg), .mem_wt_regWrite(mem_wt_regWrite),
    .mem_wt_regToWrite(mem_wt_regToWrite), .mem_stall(mem_stall),
    .wb_memToReg(wb_memToReg), .wb_regWrite(wb_regWrite),
    .wb_regToWrite(wb_regToWrite), .wb_ALUresult(wb_ALUresult),
    .wb_readData(wb_readData), .wb_writeData(wb_writeData), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: contents of the WB stage and whether an access is open.
  bit          m_busy;
  int          m_waits;     // WAIT cycles spent without ack
  int          mem_since;   // cycles since the open access was first issued
  bit          m_err;
  bit          m_rw, m_m2r;
  logic [4:0]  m_rdx;
  logic [31:0] m_alu, m_rdata;
  bit          rdata_fixed;
  logic [31:0] rdata_val;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_waits = 0; mem_since = 0; m_err = 0;
    m_rw = 0; m_m2r = 0; m_rdx = '0; m_alu = '0; m_rdata = '0;
  endtask

  task automatic check_wb(input string pfx);
    check_eq({pfx, "_regWrite"},  32'(wb_regWrite),   32'(m_rw));
    check_eq({pfx, "_memToReg"},  32'(wb_memToReg),   32'(m_m2r));
    check_eq({pfx, "_regToWrite"},32'(wb_regToWrite), 32'(m_rdx));
    check_eq({pfx, "_ALUresult"}, wb_ALUresult,       m_alu);
    check_eq({pfx, "_readData"},  wb_readData,        m_rdata);
    check_eq({pfx, "_writeData"}, wb_writeData,       m_m2r ? m_rdata : m_alu);
    check_eq({pfx, "_mem_err"},   32'(mem_err),       32'(m_err));
  endtask

  // One clock cycle, entered and left at posedge+1. lat<0 means never ack.
  task automatic tick(input int lat);
    bit          access, req, ack;
    logic [31:0] rd;
    access = mem_memRead | mem_memWrite;
    req    = rst && (m_busy || access);
    ack    = req && (lat >= 0) && (mem_since == lat);
    rd     = rdata_fixed ? rdata_val : $urandom();
    dmem_bus.dmem_ack   = ack;
    dmem_bus.dmem_rdata = rd;
    #2;
    check_eq("dmem_req",   32'(dmem_bus.dmem_req), 32'(req));
    check_eq("dmem_we",    32'(dmem_bus.dmem_we),  32'(mem_memWrite));
    check_eq("dmem_addr",  dmem_bus.dmem_addr,     mem_ALUresult);
    check_eq("dmem_wdata", dmem_bus.dmem_wdata,    mem_finalReadData2);
    check_eq("mem_stall",  32'(mem_stall),         32'(req && !ack));
    if (!req || ack) begin
      // instruction retires now
      m_rw = mem_wt_regWrite; m_m2r = mem_wt_memToReg;
      m_rdx = mem_wt_regToWrite; m_alu = mem_ALUresult;
      m_rdata = (access && !mem_memWrite) ? rd : 32'h0;
      m_busy = 0; m_waits = 0; mem_since = 0;
    end else begin
      m_rw = 0; m_m2r = 0;
      if (m_busy) m_waits++;
      m_busy = 1;
      mem_since++;
`ifdef MEM_WB_TIMEOUT_EN
      if (m_waits == TIMEOUT) begin
        m_busy = 0; m_waits = 0; mem_since = 0; m_err = 1;
      end
`endif
    end
    @(posedge clk); #1;
    check_wb("wb");
  endtask

  // Present one instruction and hold it while the model says it is stalled.
  task automatic run_instr(input bit rdq, input bit wrq, input bit m2r, input bit rw,
                           input logic [4:0] rdx, input logic [31:0] alu,
                           input logic [31:0] sd, input int lat, input int max_cycles);
    int n;
    mem_memRead = rdq; mem_memWrite = wrq; mem_wt_memToReg = m2r;
    mem_wt_regWrite = rw; mem_wt_regToWrite = rdx;
    mem_ALUresult = alu; mem_finalReadData2 = sd;
    n = 0;
    do begin
      tick(lat);
      n++;
    end while (m_busy && n < max_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, lat;
    rst = 1'b0;
    mem_memRead = 0; mem_memWrite = 0; mem_wt_memToReg = 0; mem_wt_regWrite = 0;
    mem_wt_regToWrite = '0; mem_ALUresult = '0; mem_finalReadData2 = '0;
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = '0;
    rdata_fixed = 0; rdata_val = '0;
    model_reset();
    #1;
    check_wb("rst");
    check_eq("rst_dmem_req", 32'(dmem_bus.dmem_req), 32'h0);
    check_eq("rst_stall",    32'(mem_stall),         32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // ALU op, no memory access
    run_instr(0, 0, 0, 1, 5'd5, 32'h1234, 32'h0, 0, 1);
    // Load with zero-wait ack
    rdata_fixed = 1; rdata_val = 32'hDEADBEEF;
    run_instr(1, 0, 1, 1, 5'd7, 32'h40, 32'h0, 0, 10);
    // Store acked after 3 cycles
    run_instr(0, 1, 0, 0, 5'd0, 32'h80, 32'hA5A5A5A5, 3, 10);
    // Load acked after 2 cycles
    rdata_val = 32'h0BADF00D;
    run_instr(1, 0, 1, 1, 5'd9, 32'h44, 32'h0, 2, 10);
    // Read and write both high behaves as a store
    run_instr(1, 1, 1, 1, 5'd3, 32'h48, 32'h11223344, 1, 10);
    rdata_fixed = 0;

    // Randomized instruction stream with random memory latency
    for (int i = 0; i < 300; i++) begin
      op  = int'($urandom_range(0, 3));
      lat = int'($urandom_range(0, 4));
      run_instr(op == 1 || op == 3, op >= 2, 1'($urandom()), 1'($urandom()),
                5'($urandom()), $urandom(), $urandom(), lat, 20);
    end

    // Memory never answers: abort with macro, endless stall without it
    run_instr(1, 0, 1, 1, 5'd12, 32'h100, 32'h0, -1, TIMEOUT + 5);
    repeat (3) tick(-1);

    // Reset while an access is outstanding
    run_instr(1, 0, 1, 1, 5'd13, 32'h104, 32'h0, -1, 3);
    rst = 1'b0;
    dmem_bus.dmem_ack = 1'b0;
    #1;
    model_reset();
    check_eq("rstw_dmem_req", 32'(dmem_bus.dmem_req), 32'h0);
    check_eq("rstw_stall",    32'(mem_stall),         32'h0);
    check_wb("rstw");
    @(posedge clk); #1;
    rst = 1'b1;

    // Resume after reset
    run_instr(0, 0, 0, 1, 5'd21, 32'hCAFE, 32'h0, 0, 1);
    run_instr(1, 0, 1, 1, 5'd22, 32'h200, 32'h0, 1, 10);
    run_instr(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
